fnd_msg_sequencer: RTL and testbench
====================================

// Module: fnd_msg_sequencer
// PURPOSE
//  Upstream feeder of the 6-digit FND segment driver. Turns calculator events (operator chosen,
//  result ready, error, greeting) into a timed sequence of fnd_serial words: operator label, then
//  ANS/-ANS label, then the numeric result. Error is shown blinking. All timing is counted in fnd_clk cycles.
// PARAMETERS
//  HOLD_TICKS   1000  cycles each label (operator, ANS/-ANS, HAPPY) stays on display; must be >= 1
//  BLINK_TICKS   500  half-period of the Error blink (Error on, then NULL), in cycles; must be >= 1
// PORTS
//  fnd_clk     in   1   display clock; all state on posedge
//  rst         in   1   asynchronous, active-low reset
//  op_valid    in   1   single-cycle strobe: new operator selected
//  op_code     in   3   1=MUL 2=DIV 3=PLUS 4=MINUS 5=MOD; 0,6,7 illegal
//  res_valid   in   1   result offered; accepted on a cycle where res_valid && res_ready
//  res_data    in   32  signed two's-complement result
//  res_ready   out  1   high when the 1-deep pending-result slot is empty
//  err         in   1   single-cycle strobe: upstream error
//  greet       in   1   single-cycle strobe: show HAPPY
//  fnd_serial  out  32  word to the segment driver (code or signed value)
//  busy        out  1   high in LABEL, ANS, GREET
// BEHAVIOUR
//  Display codes (shared package): NULL=32'h00CC_0000 ERR=32'h00EE_0000 MUL=32'h0010_0000
//   DIV=32'h0020_0000 PLUS=32'h0030_0000 MINUS=32'h0040_0000 MOD=32'h0050_0000
//   HAPPY=32'h00A0_0000 ANS=32'h00B0_0000 NANS=32'hE0B0_0000.
//  Reset: state IDLE, fnd_serial=NULL, busy=0, res_ready=1, pending slot empty, counters 0.
//  All outputs registered; an event sampled at edge N is reflected on fnd_serial after edge N.
//  States:
//   IDLE   : fnd_serial=NULL.
//   LABEL  : fnd_serial=operator code for HOLD_TICKS cycles, then ANS if pending slot full, else WAIT.
//   WAIT   : keep operator code; on accepted result go to ANS.
//   ANS    : fnd_serial=NANS if pending value <0 else ANS, for HOLD_TICKS cycles, then RESULT.
//   RESULT : fnd_serial=pending value; slot released (res_ready=1) on entry; stays until next event.
//   ERROR  : fnd_serial alternates ERR / NULL every BLINK_TICKS, starting with ERR.
//   GREET  : fnd_serial=HAPPY for HOLD_TICKS cycles, then IDLE.
//  Transitions from any state, priority err > op_valid > greet > res_valid:
//   err -> ERROR, pending slot cleared.
//   op_valid, legal code -> LABEL, hold counter restarted, pending slot cleared; illegal code -> ERROR.
//   greet -> GREET, except while in LABEL/WAIT/ANS where it is ignored.
//   accepted result in IDLE/RESULT/ERROR -> ANS directly (label skipped).
//  Accepting a result: pending slot loaded; res_ready drops the cycle after.
//   res_valid with res_ready=0 is ignored.
//  Range: value outside -99999..999999 is not stored; ERROR is entered instead.
//   Legal values equal to a display code are impossible within that range (codes > 999999 or negative < -99999).
//  Simultaneous op_valid+res_valid: op wins; slot is cleared, then this cycle's result is loaded; LABEL shown first, then ANS.
//  Counters: width $clog2(max(HOLD,BLINK)+1); terminal count = PARAM-1; no wrap issues since counter reloads on every state entry.
//  Reset mid-sequence: immediate return to reset values; no residual pending result.
// STRUCTURE
//  fnd_codes_pkg: display-code localparams above, op_code values, state encoding.
//  Sub-module fnd_tick_timer: loadable down-counter with done flag, used for hold and blink timing.
//  Top holds FSM, pending-result register and output mux.
// TESTING (bench: HOLD_TICKS=4, BLINK_TICKS=2)
//  reset release -> fnd_serial=00CC_0000, res_ready=1, busy=0.
//  op_valid op=3, then res 42 two cycles later -> PLUS 4 cyc, ANS 4 cyc, then 42 held; res_ready 0 until RESULT.
//  op_valid op=4 with res_data=-7 same cycle -> MINUS 4 cyc, E0B0_0000 4 cyc, then FFFF_FFF9.
//  res 1_000_000 in IDLE -> ERR 2 cyc, NULL 2 cyc, ERR ... ; op_valid op=1 exits blink to MUL.
//  err during ANS with pending 5 -> ERROR next cycle, slot cleared, res_ready=1.
//  op_valid op=6 -> ERROR; greet in RESULT -> HAPPY 4 cyc -> NULL; rst low mid-LABEL -> NULL at once.

Source files
------------

// File: rtl/fnd_codes_pkg.sv
// fnd_codes_pkg
//   Shared display codes, operator codes and sequencer state encoding for the
//   FND message path. The display codes are words the segment driver decodes
//   as glyph strings. None of them can collide with a displayable numeric value.
package fnd_codes_pkg;

    localparam logic [31:0] CODE_NULL  = 32'h00CC_0000;
    localparam logic [31:0] CODE_ERR   = 32'h00EE_0000;
    localparam logic [31:0] CODE_MUL   = 32'h0010_0000;
    localparam logic [31:0] CODE_DIV   = 32'h0020_0000;
    localparam logic [31:0] CODE_PLUS  = 32'h0030_0000;
    localparam logic [31:0] CODE_MINUS = 32'h0040_0000;
    localparam logic [31:0] CODE_MOD   = 32'h0050_0000;
    localparam logic [31:0] CODE_HAPPY = 32'h00A0_0000;
    localparam logic [31:0] CODE_ANS   = 32'h00B0_0000;
    localparam logic [31:0] CODE_NANS  = 32'hE0B0_0000;

    localparam logic [2:0] OP_MUL   = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_PLUS  = 3'd3;
    localparam logic [2:0] OP_MINUS = 3'd4;
    localparam logic [2:0] OP_MOD   = 3'd5;

    // Displayable numeric window of the 6-digit driver
    localparam logic signed [31:0] VAL_MIN = -32'sd99999;
    localparam logic signed [31:0] VAL_MAX =  32'sd999999;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LABEL,
        ST_WAIT,
        ST_ANS,
        ST_RESULT,
        ST_ERROR,
        ST_GREET
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op >= OP_MUL) && (op <= OP_MOD);
    endfunction

    function automatic logic [31:0] op_label(input logic [2:0] op);
        case (op)
            OP_MUL:   return CODE_MUL;
            OP_DIV:   return CODE_DIV;
            OP_PLUS:  return CODE_PLUS;
            OP_MINUS: return CODE_MINUS;
            OP_MOD:   return CODE_MOD;
            default:  return CODE_ERR;
        endcase
    endfunction

endpackage

// File: rtl/fnd_tick_timer.sv
// fnd_tick_timer
//   Loadable down-counter. Loading N-1 makes done rise N cycles after the
//   load edge. The counter parks at zero, so done stays high until reloaded.
// Ports
//   fnd_clk   clock
//   rst       asynchronous active-low reset
//   load      load load_val this cycle (takes precedence over counting)
//   load_val  value to load
//   done      counter is at zero
module fnd_tick_timer #(
    parameter int W = 4
) (
    input  logic         fnd_clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge fnd_clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/fnd_msg_sequencer.sv
// fnd_msg_sequencer
//   Turns calculator events into a timed sequence of words for the 6-digit
//   FND driver: operator label, then ANS/-ANS, then the numeric result.
//   Errors blink. HAPPY is shown on greet.
// Ports
//   fnd_clk     display clock
//   rst         asynchronous active-low reset
//   op_valid    strobe: new operator (op_code 1..5 legal)
//   op_code     operator code
//   res_valid   result offered; taken when res_valid && res_ready
//   res_data    signed result
//   res_ready   pending-result slot is empty
//   err         strobe: upstream error
//   greet       strobe: show HAPPY
//   fnd_serial  registered word to the segment driver
//   busy        registered; high in LABEL, ANS, GREET
module fnd_msg_sequencer
    import fnd_codes_pkg::*;
#(
    parameter int HOLD_TICKS  = 1000,
    parameter int BLINK_TICKS = 500
) (
    input  logic        fnd_clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic        res_valid,
    input  logic [31:0] res_data,
    output logic        res_ready,
    input  logic        err,
    input  logic        greet,
    output logic [31:0] fnd_serial,
    output logic        busy
);

    localparam int MAX_TICKS = (HOLD_TICKS > BLINK_TICKS) ? HOLD_TICKS : BLINK_TICKS;
    localparam int CW = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] BLINK_LD = CW'(BLINK_TICKS - 1);

    state_t             state, state_d;
    logic               pend_full, pend_full_d;
    logic [31:0]        pend_data, pend_data_d;
    logic [2:0]         op_q, op_d;
    logic               blink_off, blink_off_d;
    logic               t_load, t_done;
    logic [CW-1:0]      t_val;
    logic [31:0]        serial_d;
    logic               busy_d;
    logic               accept, in_range, moved;
    logic signed [31:0] sdata;

    assign sdata     = res_data;
    assign accept    = res_valid & ~pend_full;
    assign in_range  = (sdata >= VAL_MIN) && (sdata <= VAL_MAX);
    assign res_ready = ~pend_full;

    fnd_tick_timer #(.W(CW)) u_timer (
        .fnd_clk  (fnd_clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    always_comb begin
        state_d     = state;
        pend_full_d = pend_full;
        pend_data_d = pend_data;
        op_d        = op_q;
        blink_off_d = blink_off;
        t_load      = 1'b0;
        t_val       = HOLD_LD;
        moved       = 1'b0;

        if (err || (op_valid && !op_legal(op_code))) begin
            state_d     = ST_ERROR;
            pend_full_d = 1'b0;
            blink_off_d = 1'b0;
            t_load      = 1'b1;
            t_val       = BLINK_LD;
        end else if (op_valid) begin
            // Slot is cleared first, so a result accepted in the same cycle survives
            state_d     = ST_LABEL;
            op_d        = op_code;
            pend_full_d = accept && in_range;
            if (accept && in_range) pend_data_d = res_data;
            t_load      = 1'b1;
        end else if (greet && !(state inside {ST_LABEL, ST_WAIT, ST_ANS})) begin
            // A result taken alongside greet is kept and shown after HAPPY
            state_d = ST_GREET;
            t_load  = 1'b1;
            if (accept && in_range) begin
                pend_full_d = 1'b1;
                pend_data_d = res_data;
            end
        end else if (accept && !in_range) begin
            state_d     = ST_ERROR;
            blink_off_d = 1'b0;
            t_load      = 1'b1;
            t_val       = BLINK_LD;
        end else begin
            if (accept) begin
                pend_full_d = 1'b1;
                pend_data_d = res_data;
                if (state inside {ST_IDLE, ST_RESULT, ST_ERROR, ST_WAIT}) begin
                    state_d = ST_ANS;
                    t_load  = 1'b1;
                    moved   = 1'b1;
                end
            end
            // LABEL/GREET keep their hold running even when a result lands
            if (!moved && t_done) begin
                case (state)
                    ST_LABEL, ST_GREET: begin
                        if (pend_full_d) begin
                            state_d = ST_ANS;
                            t_load  = 1'b1;
                        end else begin
                            state_d = (state == ST_LABEL) ? ST_WAIT : ST_IDLE;
                        end
                    end
                    ST_ANS: begin
                        state_d     = ST_RESULT;
                        pend_full_d = 1'b0;
                    end
                    ST_ERROR: begin
                        blink_off_d = ~blink_off;
                        t_load      = 1'b1;
                        t_val       = BLINK_LD;
                    end
                    default: ;
                endcase
            end
        end

        case (state_d)
            ST_LABEL, ST_WAIT: serial_d = op_label(op_d);
            ST_ANS:            serial_d = pend_data_d[31] ? CODE_NANS : CODE_ANS;
            ST_RESULT:         serial_d = pend_data_d;
            ST_ERROR:          serial_d = blink_off_d ? CODE_NULL : CODE_ERR;
            ST_GREET:          serial_d = CODE_HAPPY;
            default:           serial_d = CODE_NULL;
        endcase
        busy_d = state_d inside {ST_LABEL, ST_ANS, ST_GREET};
    end

    always_ff @(posedge fnd_clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pend_full  <= 1'b0;
            pend_data  <= '0;
            op_q       <= '0;
            blink_off  <= 1'b0;
            fnd_serial <= CODE_NULL;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            pend_full  <= pend_full_d;
            pend_data  <= pend_data_d;
            op_q       <= op_d;
            blink_off  <= blink_off_d;
            fnd_serial <= serial_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_fnd_msg_sequencer.sv
// tb_fnd_msg_sequencer
//   Directed walk through the main display sequences with literal expectations,
//   then randomized events compared every cycle against a timestamp-based model.
module tb_fnd_msg_sequencer;

    localparam int H = 4;
    localparam int B = 2;

    logic        fnd_clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = '0;
    logic        res_valid = 1'b0;
    logic [31:0] res_data = '0;
    logic        err = 1'b0;
    logic        greet = 1'b0;
    logic        res_ready, busy;
    logic [31:0] fnd_serial;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    fnd_msg_sequencer #(.HOLD_TICKS(H), .BLINK_TICKS(B)) dut (
        .fnd_clk    (fnd_clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .err        (err),
        .greet      (greet),
        .fnd_serial (fnd_serial),
        .busy       (busy)
    );

    always #5 fnd_clk = ~fnd_clk;

    // ---------------- behavioural model ----------------
    // Each display phase is remembered by its entry edge; durations and the
    // blink phase follow from elapsed edge count.
    localparam int M_IDLE = 0, M_LABEL = 1, M_WAIT = 2, M_ANS = 3,
                   M_RES = 4, M_ERR = 5, M_GREET = 6;

    int          m_mode = M_IDLE;
    longint      cyc = 0, t0 = 0;
    logic [31:0] m_lbl = '0, m_val = '0;
    bit          m_full = 1'b0;
    logic [31:0] m_serial = 32'h00CC_0000;
    bit          m_ready = 1'b1, m_busy = 1'b0;

    function automatic bit fits(input logic [31:0] d);
        longint v;
        v = longint'($signed(d));
        return (v >= -99999) && (v <= 999999);
    endfunction

    task automatic enter(input int m);
        m_mode = m;
        t0 = cyc;
    endtask

    task automatic m_step();
        bit acc, ok, moved;
        acc = res_valid && !m_full;
        ok = fits(res_data);
        moved = 1'b0;
        if (err) begin
            enter(M_ERR); m_full = 1'b0;
        end else if (op_valid) begin
            m_full = 1'b0;
            if (op_code >= 3'd1 && op_code <= 3'd5) begin
                enter(M_LABEL);
                m_lbl = 32'(op_code) * 32'h0010_0000;
                if (acc && ok) begin m_full = 1'b1; m_val = res_data; end
            end else begin
                enter(M_ERR);
            end
        end else if (greet && m_mode != M_LABEL && m_mode != M_WAIT && m_mode != M_ANS) begin
            enter(M_GREET);
            if (acc && ok) begin m_full = 1'b1; m_val = res_data; end
        end else if (acc && !ok) begin
            enter(M_ERR);
        end else begin
            if (acc) begin
                m_full = 1'b1; m_val = res_data;
                if (m_mode == M_IDLE || m_mode == M_RES || m_mode == M_ERR || m_mode == M_WAIT) begin
                    enter(M_ANS); moved = 1'b1;
                end
            end
            if (!moved && (cyc - t0) == H) begin
                if (m_mode == M_LABEL) enter(m_full ? M_ANS : M_WAIT);
                else if (m_mode == M_GREET) enter(m_full ? M_ANS : M_IDLE);
                else if (m_mode == M_ANS) begin enter(M_RES); m_full = 1'b0; end
            end
        end
    endtask

    task automatic m_out();
        case (m_mode)
            M_LABEL, M_WAIT: m_serial = m_lbl;
            M_ANS:   m_serial = ($signed(m_val) < 0) ? 32'hE0B0_0000 : 32'h00B0_0000;
            M_RES:   m_serial = m_val;
            M_ERR:   m_serial = ((((cyc - t0) / B) % 2) == 0) ? 32'h00EE_0000 : 32'h00CC_0000;
            M_GREET: m_serial = 32'h00A0_0000;
            default: m_serial = 32'h00CC_0000;
        endcase
        m_ready = !m_full;
        m_busy  = (m_mode == M_LABEL) || (m_mode == M_ANS) || (m_mode == M_GREET);
    endtask

    always @(posedge fnd_clk or negedge rst) begin
        if (!rst) begin
            m_mode = M_IDLE; m_full = 1'b0; t0 = cyc;
        end else begin
            cyc++;
            m_step();
        end
        m_out();
    end

    // ---------------- checking ----------------
    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, got, exp);
        end
    endtask

    // Pins both the DUT and the model to a hand-computed value
    task automatic lit(input string nm, input logic [31:0] dv, input logic [31:0] mv,
                       input logic [31:0] exp);
        cmp({nm, "_dut"}, dv, exp);
        cmp({nm, "_model"}, mv, exp);
    endtask

    always @(negedge fnd_clk) begin
        if (chk_en) begin
            cmp("serial", fnd_serial, m_serial);
            cmp("res_ready", {31'b0, res_ready}, {31'b0, m_ready});
            cmp("busy", {31'b0, busy}, {31'b0, m_busy});
        end
    end

    task automatic tick();
        @(posedge fnd_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [31:0] pick();
        int r, v;
        r = $urandom_range(0, 9);
        case (r)
            0: return 32'(-99999);
            1: return 32'(-100000);
            2: return 32'(999999);
            3: return 32'(1000000);
            4, 5, 6: begin v = int'($urandom_range(0, 2000)) - 1000; return 32'(v); end
            7: return 32'($urandom_range(0, 999999));
            8: begin v = int'($urandom_range(1, 99999)); return 32'(-v); end
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2 rst = 1'b0;
        ticks(2);
        rst = 1'b1;
        chk_en = 1'b1;
        lit("rst_serial", fnd_serial, m_serial, 32'h00CC_0000);
        lit("rst_ready", {31'b0, res_ready}, {31'b0, m_ready}, 32'd1);
        lit("rst_busy", {31'b0, busy}, {31'b0, m_busy}, 32'd0);

        // PLUS, result two cycles later
        op_valid = 1'b1; op_code = 3'd3; tick(); op_valid = 1'b0;
        lit("plus_e0", fnd_serial, m_serial, 32'h0030_0000);
        lit("plus_busy", {31'b0, busy}, {31'b0, m_busy}, 32'd1);
        tick();
        res_valid = 1'b1; res_data = 32'd42; tick(); res_valid = 1'b0;
        lit("plus_ready0", {31'b0, res_ready}, {31'b0, m_ready}, 32'd0);
        tick();
        lit("plus_e3", fnd_serial, m_serial, 32'h0030_0000);
        tick();
        lit("ans_e4", fnd_serial, m_serial, 32'h00B0_0000);
        ticks(3);
        lit("ans_e7", fnd_serial, m_serial, 32'h00B0_0000);
        lit("ans_ready0", {31'b0, res_ready}, {31'b0, m_ready}, 32'd0);
        tick();
        lit("res_42", fnd_serial, m_serial, 32'd42);
        lit("res_ready1", {31'b0, res_ready}, {31'b0, m_ready}, 32'd1);

        // MINUS with -7 in the same cycle
        op_valid = 1'b1; op_code = 3'd4; res_valid = 1'b1; res_data = 32'(-7);
        tick(); op_valid = 1'b0; res_valid = 1'b0;
        lit("minus_e0", fnd_serial, m_serial, 32'h0040_0000);
        ticks(3);
        lit("minus_e3", fnd_serial, m_serial, 32'h0040_0000);
        tick();
        lit("nans", fnd_serial, m_serial, 32'hE0B0_0000);
        ticks(4);
        lit("res_m7", fnd_serial, m_serial, 32'hFFFF_FFF9);

        // greet from RESULT
        greet = 1'b1; tick(); greet = 1'b0;
        lit("happy_e0", fnd_serial, m_serial, 32'h00A0_0000);
        ticks(3);
        lit("happy_e3", fnd_serial, m_serial, 32'h00A0_0000);
        tick();
        lit("happy_end", fnd_serial, m_serial, 32'h00CC_0000);

        // out-of-range result in IDLE -> blink
        res_valid = 1'b1; res_data = 32'd1_000_000; tick(); res_valid = 1'b0;
        lit("blink_0", fnd_serial, m_serial, 32'h00EE_0000);
        tick();
        lit("blink_1", fnd_serial, m_serial, 32'h00EE_0000);
        tick();
        lit("blink_2", fnd_serial, m_serial, 32'h00CC_0000);
        ticks(2);
        lit("blink_4", fnd_serial, m_serial, 32'h00EE_0000);
        op_valid = 1'b1; op_code = 3'd1; tick(); op_valid = 1'b0;
        lit("mul", fnd_serial, m_serial, 32'h0010_0000);

        // err during ANS with pending 5
        res_valid = 1'b1; res_data = 32'd5; tick(); res_valid = 1'b0;
        ticks(3);
        lit("ans5", fnd_serial, m_serial, 32'h00B0_0000);
        err = 1'b1; tick(); err = 1'b0;
        lit("err_ans", fnd_serial, m_serial, 32'h00EE_0000);
        lit("err_ready", {31'b0, res_ready}, {31'b0, m_ready}, 32'd1);

        // illegal op
        op_valid = 1'b1; op_code = 3'd2; tick();
        lit("div", fnd_serial, m_serial, 32'h0020_0000);
        op_code = 3'd6; tick(); op_valid = 1'b0;
        lit("op6_err", fnd_serial, m_serial, 32'h00EE_0000);

        // reset mid-LABEL
        op_valid = 1'b1; op_code = 3'd5; tick(); op_valid = 1'b0;
        lit("mod", fnd_serial, m_serial, 32'h0050_0000);
        tick();
        rst = 1'b0; #1;
        lit("rst_mid", fnd_serial, m_serial, 32'h00CC_0000);
        lit("rst_mid_busy", {31'b0, busy}, {31'b0, m_busy}, 32'd0);
        tick();
        rst = 1'b1;

        // randomized events
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 499) != 0);
            err       = ($urandom_range(0, 99) == 0);
            op_valid  = ($urandom_range(0, 24) == 0);
            op_code   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                                    : 3'($urandom_range(1, 5));
            greet     = ($urandom_range(0, 24) == 0);
            res_valid = ($urandom_range(0, 6) == 0);
            res_data  = pick();
            tick();
        end
        rst = 1'b1; err = 1'b0; op_valid = 1'b0; greet = 1'b0; res_valid = 1'b0;
        ticks(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
